// File: rtl/plane_pkg.sv
// plane_pkg: shared types and constants for the plane renderer.
// Holds the FSM state enum, opcodes, screen defaults and the sprite silhouette.
package plane_pkg;

  localparam int unsigned NUM_PLANES = 10;
  localparam int unsigned DEF_SCR_W  = 160;
  localparam int unsigned DEF_SCR_H  = 120;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAW  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } plane_state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ERASE = 2'b01,
    OP_DRAW  = 2'b10,
    OP_CLEAR = 2'b11
  } plane_op_e;

  // 4x4 silhouette, bit {y[1:0], x[1:0]}: nose row, wings, body, tail.
  localparam logic [15:0] PLANE_MASK = {4'b1110, 4'b0100, 4'b1111, 4'b0100};

  // Larger or smaller sprites sample the 4x4 silhouette scaled to their size.
  function automatic logic sprite_mask_bit(input logic [2:0] cx, input logic [2:0] cy,
                                           input int unsigned sprite_w);
    logic [1:0] mx;
    logic [1:0] my;
    case (sprite_w)
      8: begin
        mx = cx[2:1];
        my = cy[2:1];
      end
      2: begin
        mx = {cx[0], 1'b0};
        my = {cy[0], 1'b0};
      end
      default: begin
        mx = cx[1:0];
        my = cy[1:0];
      end
    endcase
    return PLANE_MASK[{my, mx}];
  endfunction

endpackage

// File: rtl/plane_renderer_if.sv
// plane_renderer_if: controller-side drive signals plus VGA pixel-write bus.
// start: enable_datapath is sampled only while busy=0; busy rises the next cycle,
// and done pulses for one cycle when busy falls; vga_we qualifies each pixel cycle.
interface plane_renderer_if;
  import plane_pkg::*;

  logic [79:0]  x_bus;
  logic [79:0]  y_bus;
  logic [9:0]   vis;
  logic [1:0]   op;
  logic         load_coord;
  logic         enable_datapath;
  logic         plot;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   vga_colour;
  logic         vga_we;
  logic         busy;
  logic         done;
  plane_state_e state;

  modport master (
    output x_bus, y_bus, vis, op, load_coord, enable_datapath, plot,
    input  vga_x, vga_y, vga_colour, vga_we, busy, done, state
  );

  modport slave (
    input  x_bus, y_bus, vis, op, load_coord, enable_datapath, plot,
    output vga_x, vga_y, vga_colour, vga_we, busy, done, state
  );

endinterface

// File: rtl/sprite_pixel_counter.sv
// sprite_pixel_counter: x-fastest raster counter with runtime limits and last flag.
// Serves both the sprite scan and the full-screen clear.
module sprite_pixel_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       step,
  input  logic [7:0] lim_x,
  input  logic [6:0] lim_y,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       last
);

  assign last = (cx == lim_x) && (cy == lim_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (init) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (cx == lim_x) begin
        cx <= '0;
        cy <= (cy == lim_y) ? '0 : cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/plane_renderer.sv
// plane_renderer: rasterises visible planes as square sprites into VGA pixel writes.
// Define PLANE_RENDER_MASK_EN to gate sprite pixels with the package silhouette.
module plane_renderer
  import plane_pkg::*;
#(
  parameter int unsigned SPRITE_W     = 4,
  parameter int unsigned SCR_W        = DEF_SCR_W,
  parameter int unsigned SCR_H        = DEF_SCR_H,
  parameter logic [2:0]  PLANE_COLOUR = 3'b111
) (
  input logic             clk,
  input logic             reset_n,
  plane_renderer_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_PLANES - 1);
  localparam logic [8:0] SCR_W9   = 9'(SCR_W);
  localparam logic [8:0] SCR_H9   = 9'(SCR_H);

  plane_state_e state;
  plane_op_e    op_q;
  logic [3:0]   idx;
  logic [79:0]  x_snap;
  logic [79:0]  y_snap;
  logic [9:0]   vis_snap;

  logic [7:0] cx;
  logic [6:0] cy;
  logic [7:0] lim_x;
  logic [6:0] lim_y;
  logic       cnt_init;
  logic       cnt_step;
  logic       cnt_last;
  logic [7:0] x_sel;
  logic [7:0] y_sel;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic       pix_on;

  assign bus.state = state;

  always_comb begin
    cnt_init = (state == IDLE) || (state == SCAN);
    cnt_step = (state == DRAW) || (state == CLEAR);
    if (op_q == OP_CLEAR) begin
      lim_x = 8'(SCR_W - 1);
      lim_y = 7'(SCR_H - 1);
    end else begin
      lim_x = 8'(SPRITE_W - 1);
      lim_y = 7'(SPRITE_W - 1);
    end
    x_sel = x_snap[{idx, 3'b000} +: 8];
    y_sel = y_snap[{idx, 3'b000} +: 8];
    // Sums are 9 bits so off-screen pixels clip instead of wrapping.
    sum_x = {1'b0, x_sel} + {1'b0, cx};
    sum_y = {1'b0, y_sel} + {2'b00, cy};
    pix_on = bus.plot && (sum_x < SCR_W9) && (sum_y < SCR_H9);
`ifdef PLANE_RENDER_MASK_EN
    pix_on = pix_on && sprite_mask_bit(cx[2:0], cy[2:0], SPRITE_W);
`endif
  end

  sprite_pixel_counter u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (cnt_init),
    .step    (cnt_step),
    .lim_x   (lim_x),
    .lim_y   (lim_y),
    .cx      (cx),
    .cy      (cy),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op_q           <= OP_NOP;
      idx            <= '0;
      x_snap         <= '0;
      y_snap         <= '0;
      vis_snap       <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_we     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.vga_we <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_coord) begin
            x_snap   <= bus.x_bus;
            y_snap   <= bus.y_bus;
            vis_snap <= bus.vis;
          end
          if (bus.enable_datapath && (bus.op != OP_NOP)) begin
            op_q     <= plane_op_e'(bus.op);
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= (bus.op == OP_CLEAR) ? CLEAR : SCAN;
          end
        end
        SCAN: begin
          if (vis_snap[idx]) begin
            state <= DRAW;
          end else if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DRAW: begin
          bus.vga_x      <= sum_x[7:0];
          bus.vga_y      <= sum_y[6:0];
          bus.vga_colour <= (op_q == OP_DRAW) ? PLANE_COLOUR : 3'b000;
          bus.vga_we     <= pix_on;
          if (cnt_last) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= SCAN;
            end
          end
        end
        CLEAR: begin
          bus.vga_x      <= cx;
          bus.vga_y      <= cy;
          bus.vga_colour <= 3'b000;
          bus.vga_we     <= bus.plot;
          if (cnt_last) state <= DONE;
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plane_renderer.sv
// tb_plane_renderer: directed self-checking bench for plane_renderer.
// Default build (PLANE_RENDER_MASK_EN undefined): solid sprites.
module tb_plane_renderer;
  import plane_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  plane_renderer_if bus();

  plane_renderer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  function automatic logic [17:0] pix(input int x, input int y, input logic [2:0] c);
    return {8'(x), 7'(y), c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.x_bus = '0;
    bus.y_bus = '0;
    bus.vis = '0;
    bus.op = OP_NOP;
    bus.load_coord = 1'b0;
    bus.enable_datapath = 1'b0;
    bus.plot = 1'b1;
  endtask

  task automatic load_planes(input logic [79:0] xb, input logic [79:0] yb, input logic [9:0] v);
    @(negedge clk);
    bus.x_bus = xb;
    bus.y_bus = yb;
    bus.vis = v;
    bus.load_coord = 1'b1;
    @(negedge clk);
    bus.load_coord = 1'b0;
  endtask

  // Returns 1ns after the accepting edge N.
  task automatic start_op(input logic [1:0] o, input logic with_load);
    @(negedge clk);
    bus.op = o;
    bus.enable_datapath = 1'b1;
    bus.load_coord = with_load;
    @(posedge clk);
    #1;
    bus.enable_datapath = 1'b0;
    bus.load_coord = 1'b0;
    bus.op = OP_NOP;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_cmp++; if (bus.state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE); end
    n_cmp++; if (bus.vga_x !== 8'd0) begin n_err++; $display("FAIL reset_vga_x got=%0d exp=0", bus.vga_x); end
    n_cmp++; if (bus.vga_y !== 7'd0) begin n_err++; $display("FAIL reset_vga_y got=%0d exp=0", bus.vga_y); end
    n_cmp++; if (bus.vga_colour !== 3'd0) begin n_err++; $display("FAIL reset_colour got=%0d exp=0", bus.vga_colour); end
    n_cmp++; if (bus.vga_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", bus.vga_we); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_nop();
    int active;
    active = 0;
    start_op(OP_NOP, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== IDLE) active++;
    end
    n_cmp++; if (active !== 0) begin n_err++; $display("FAIL nop_ignored active_cycles=%0d exp=0", active); end
  endtask

  task automatic test_draw_single();
    int writes;
    int first_k;
    logic [17:0] got;
    logic [17:0] e;
    writes = 0;
    first_k = -1;
    load_planes(80'd10, 80'd20, 10'b0000000001);
    for (int j = 0; j < 16; j++) exp_q.push_back(pix(10 + j % 4, 20 + j / 4, 3'b111));
    start_op(OP_DRAW, 1'b0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL draw_busy_rise got=%b exp=1", bus.busy); end
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (bus.vga_we === 1'b1) begin
        if (first_k < 0) first_k = k;
        writes++;
        got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL draw_extra_write got=%h exp=none cycle=%0d", got, k);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_err++; $display("FAIL draw_pixel cycle=%0d got=%h exp=%h", k, got, e); end
        end
      end
      n_cmp++; if (bus.done !== (k == 27)) begin n_err++; $display("FAIL draw_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 27)); end
      n_cmp++; if (bus.busy !== (k < 27)) begin n_err++; $display("FAIL draw_busy cycle=%0d got=%b exp=%b", k, bus.busy, (k < 27)); end
    end
    n_cmp++; if (first_k !== 2) begin n_err++; $display("FAIL draw_first_cycle got=%0d exp=2", first_k); end
    n_cmp++; if (writes !== 16) begin n_err++; $display("FAIL draw_write_count got=%0d exp=16", writes); end
    exp_q.delete();
  endtask

  task automatic test_empty();
    int writes;
    writes = 0;
    load_planes(80'd5, 80'd5, 10'b0);
    start_op(OP_DRAW, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.vga_we === 1'b1) writes++;
      n_cmp++; if (bus.done !== (k == 11)) begin n_err++; $display("FAIL empty_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 11)); end
      n_cmp++; if (bus.busy !== (k < 11)) begin n_err++; $display("FAIL empty_busy cycle=%0d got=%b exp=%b", k, bus.busy, (k < 11)); end
    end
    n_cmp++; if (writes !== 0) begin n_err++; $display("FAIL empty_writes got=%0d exp=0", writes); end
  endtask

  task automatic test_clip();
    int writes;
    int done_k;
    logic [17:0] got;
    logic [17:0] e;
    writes = 0;
    done_k = -1;
    load_planes(80'd158 << 24, 80'd118 << 24, 10'b0000001000);
    exp_q.push_back(pix(158, 118, 3'b000));
    exp_q.push_back(pix(159, 118, 3'b000));
    exp_q.push_back(pix(158, 119, 3'b000));
    exp_q.push_back(pix(159, 119, 3'b000));
    start_op(OP_ERASE, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      if (bus.vga_we === 1'b1) begin
        writes++;
        got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL clip_extra_write got=%h exp=none cycle=%0d", got, k);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_err++; $display("FAIL clip_pixel cycle=%0d got=%h exp=%h", k, got, e); end
        end
      end
    end
    n_cmp++; if (writes !== 4) begin n_err++; $display("FAIL clip_write_count got=%0d exp=4", writes); end
    n_cmp++; if (done_k !== 27) begin n_err++; $display("FAIL clip_done_cycle got=%0d exp=27", done_k); end
    exp_q.delete();
  endtask

  task automatic test_clear(input logic p);
    int writes;
    int done_k;
    int order_err;
    int ex;
    int ey;
    logic [17:0] got;
    logic [17:0] last_w;
    writes = 0;
    done_k = -1;
    order_err = 0;
    ex = 0;
    ey = 0;
    last_w = '0;
    @(negedge clk);
    bus.plot = p;
    start_op(OP_CLEAR, 1'b0);
    for (int k = 1; k <= 19205; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      if (bus.vga_we === 1'b1) begin
        writes++;
        got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        last_w = got;
        if (got !== pix(ex, ey, 3'b000)) order_err++;
        if (ex == 159) begin ex = 0; ey++; end else ex++;
      end
    end
    n_cmp++; if (writes !== (p ? 19200 : 0)) begin n_err++; $display("FAIL clear_writes plot=%b got=%0d exp=%0d", p, writes, (p ? 19200 : 0)); end
    n_cmp++; if (done_k !== 19201) begin n_err++; $display("FAIL clear_done_cycle plot=%b got=%0d exp=19201", p, done_k); end
    n_cmp++; if (order_err !== 0) begin n_err++; $display("FAIL clear_order plot=%b bad=%0d exp=0", p, order_err); end
    if (p) begin
      n_cmp++; if (last_w !== pix(159, 119, 3'b000)) begin n_err++; $display("FAIL clear_last got=%h exp=%h", last_w, pix(159, 119, 3'b000)); end
    end
    @(negedge clk);
    bus.plot = 1'b1;
  endtask

  task automatic test_load_while_busy();
    int bad_x;
    int first_k;
    logic [17:0] first_w;
    bad_x = 0;
    load_planes(80'd10, 80'd20, 10'b0000000001);
    start_op(OP_DRAW, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (bus.vga_we === 1'b1 && (bus.vga_x < 8'd10 || bus.vga_x > 8'd13)) bad_x++;
      if (k == 3) begin bus.x_bus = 80'd50; bus.load_coord = 1'b1; end
      if (k == 4) bus.load_coord = 1'b0;
    end
    n_cmp++; if (bad_x !== 0) begin n_err++; $display("FAIL busy_load_x bad=%0d exp=0", bad_x); end
    // Second run without a fresh load must still use x=10.
    first_k = -1; first_w = '0;
    start_op(OP_DRAW, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (bus.vga_we === 1'b1 && first_k < 0) begin first_k = k; first_w = {bus.vga_x, bus.vga_y, bus.vga_colour}; end
    end
    n_cmp++; if (first_w !== pix(10, 20, 3'b111)) begin n_err++; $display("FAIL stale_snapshot got=%h exp=%h", first_w, pix(10, 20, 3'b111)); end
    // Load and start in the same cycle: the new snapshot is used.
    first_k = -1; first_w = '0;
    bus.x_bus = 80'd60;
    bus.y_bus = 80'd5;
    bus.vis = 10'b0000000001;
    start_op(OP_DRAW, 1'b1);
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (bus.vga_we === 1'b1 && first_k < 0) begin first_k = k; first_w = {bus.vga_x, bus.vga_y, bus.vga_colour}; end
    end
    n_cmp++; if (first_w !== pix(60, 5, 3'b111)) begin n_err++; $display("FAIL load_and_start got=%h exp=%h", first_w, pix(60, 5, 3'b111)); end
    n_cmp++; if (first_k !== 2) begin n_err++; $display("FAIL load_and_start_cycle got=%0d exp=2", first_k); end
  endtask

  task automatic test_reset_mid_draw();
    int stray;
    stray = 0;
    load_planes(80'd10, 80'd20, 10'b0000000001);
    start_op(OP_DRAW, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (bus.vga_we !== 1'b1) begin n_err++; $display("FAIL mid_we_before got=%b exp=1", bus.vga_we); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.state !== IDLE) begin n_err++; $display("FAIL mid_state got=%0d exp=%0d", bus.state, IDLE); end
    n_cmp++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin n_err++; $display("FAIL mid_pixel got=%h exp=0", {bus.vga_x, bus.vga_y, bus.vga_colour}); end
    n_cmp++; if ({bus.vga_we, bus.busy, bus.done} !== 3'b000) begin n_err++; $display("FAIL mid_ctrl got=%b exp=000", {bus.vga_we, bus.busy, bus.done}); end
    repeat (2) begin @(posedge clk); #1; if (bus.done !== 1'b0) stray++; end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.vga_we !== 1'b0) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL mid_no_done stray=%0d exp=0", stray); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_nop();
    test_draw_single();
    test_empty();
    test_clip();
    test_load_while_busy();
    test_clear(1'b1);
    test_clear(1'b0);
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/plane_renderer.md
Name: plane_renderer

Overview:
- Datapath-side consumer of the plane controller's drive signals: coordinate snapshot strobe, draw/erase opcode, start strobe and visibility mask.
- Rasterises each visible plane as a square sprite into pixel writes for the VGA adapter (160x120, 3-bit colour).
- Signals completion back to the controller so the next move/erase/draw step can be issued.

Parameters:
- SPRITE_W, 4, sprite edge length in pixels (power of two, 2..8)
- SCR_W, 160, screen width; pixels with x >= SCR_W are suppressed
- SCR_H, 120, screen height; pixels with y >= SCR_H are suppressed
- PLANE_COLOUR, 3'b111, colour used for draw operations

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x_bus  in  80  packed x coords; plane i occupies [8i+7:8i]
- y_bus  in  80  packed y coords; plane i occupies [8i+7:8i]
- vis  in  10  visibility mask; bit i enables plane i
- op  in  2  00 nop, 01 erase, 10 draw, 11 clear screen
- load_coord  in  1  snapshot x_bus/y_bus/vis into internal registers
- enable_datapath  in  1  start strobe; samples op
- plot  in  1  global write gate, ANDed into vga_we
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_we  out  1  pixel write enable
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - vga_x, vga_y, vga_colour, vga_we, busy and done all 0.
  - Snapshot registers and all counters 0.
- IDLE:
  - load_coord=1 captures x_bus, y_bus and vis on the clock edge.
  - enable_datapath=1 with op!=00 latches op, sets busy the next cycle, and moves to SCAN (or CLEAR when op=11).
  - op=00 with enable_datapath is ignored.
  - load_coord and enable_datapath in the same cycle: the snapshot is taken first, and the operation uses the new snapshot.
  - While busy, load_coord and enable_datapath are ignored.
- SCAN:
  - idx starts at 0 and advances by one per cycle.
  - vis_snap[idx]=1: go to DRAW with px=py=0.
  - vis_snap[idx]=0 and idx=9: go to DONE; otherwise idx+1.
- DRAW: one pixel per cycle, registered outputs.
  - vga_x = x_snap[idx]+px and vga_y = y_snap[idx]+py, both computed 9 bits wide.
  - Colour is PLANE_COLOUR for op=10 and 3'b000 for op=01.
  - vga_we = plot AND (sum_x < SCR_W) AND (sum_y < SCR_H); no wrap-around, clipped pixels are simply not written.
  - px increments first; on px=SPRITE_W-1, px wraps to 0 and py increments.
  - After the last pixel: idx=9 goes to DONE, otherwise idx+1 and back to SCAN.
- CLEAR:
  - Sweeps x 0..SCR_W-1 inner, y 0..SCR_H-1 outer, writing colour 000 with vga_we=plot.
  - Then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, busy drops to 0 in that same cycle, state returns to IDLE.
  - vga_we is 0 in DONE and IDLE.
- Timing:
  - Start accepted at edge N; first SCAN evaluation at cycle N+1; first pixel visible at N+2 if plane 0 is visible.
  - Total busy cycles = 10 + SPRITE_W^2 * popcount(vis_snap) + 1.
- Reset asserted mid-operation aborts immediately to the reset state; no done pulse is produced.

Optional Feature:
- Macro: PLANE_RENDER_MASK_EN.
- Defined:
  - A fixed SPRITE_W x SPRITE_W shape ROM, plane silhouette, from the package.
  - Pixels whose mask bit is 0 get vga_we=0.
  - The pixel cycle count is unchanged.
- Undefined: solid square sprite, every in-screen pixel written.

Decomposition:
- Shared package plane_pkg holds:
  - State enum (IDLE, SCAN, DRAW, CLEAR, DONE).
  - Op codes OP_NOP/OP_ERASE/OP_DRAW/OP_CLEAR.
  - NUM_PLANES=10, SCR_W/SCR_H defaults.
  - 4x4 silhouette mask constant.
- One sub-module, sprite_pixel_counter:
  - px/py raster counter with wrap and last flag.
  - Reused by CLEAR with width SCR_W x SCR_H.

Test Plan:
- Reset mid-DRAW (busy=1, vga_we=1) -> next cycle all outputs 0, state IDLE, no done.
- vis=10'b0000000001, x0=10, y0=20, op=10, plot=1 -> 16 writes at (10..13, 20..23), colour 111, x-fastest order; first write at N+2; done at cycle N+27.
- vis=0, op=10 -> no vga_we; done pulse after 11 cycles; busy high for those cycles.
- Plane 3 at x=158, y=118, op=01 -> only (158,118), (159,118), (158,119), (159,119) written with colour 000; other 12 pixels suppressed.
- op=11 with plot=1 -> exactly 19200 writes, last at (159,119), then done; with plot=0 the same duration but zero writes.
- load_coord pulsed while busy with new x_bus -> output coordinates unchanged until next start; new snapshot used only after a fresh load_coord in IDLE.
